// File: rtl/dice_turn_sequencer.sv
// Purpose: automated turn controller; rolls the game core, waits for it to settle, samples positions/wins.
// Latency: start/step seen in IDLE gives roll the next cycle; one turn takes 1+SETTLE_CYCLES+1+1+GAP_CYCLES cycles.
// Backpressure: none; step while busy is dropped, and start is only consulted in IDLE and at the end of a turn.
module dice_turn_sequencer #(
  parameter int SETTLE_CYCLES = 4,
  parameter int GAP_CYCLES    = 2,
  parameter int MAX_TURNS     = 0,
  parameter int POS_W         = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [POS_W-1:0] position1,
  input  logic [POS_W-1:0] position2,
  input  logic             win1,
  input  logic             win2,
  output logic             roll,
  output logic             player_switch,
  output logic             busy,
  output logic             turn_done,
  output logic [POS_W-1:0] last_pos1,
  output logic [POS_W-1:0] last_pos2,
  output logic [7:0]       turn_count,
  output logic [1:0]       winner,
  output logic             game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ROLL,
    S_SETTLE,
    S_SAMPLE,
    S_SWITCH,
    S_GAP,
    S_OVER
  } state_t;

  // Counters are loaded with N-1 and the state exits when they reach zero, giving exactly N cycles.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD    = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [7:0] TURN_LIMIT  = 8'(MAX_TURNS);
  localparam bit         LIMIT_ON    = (MAX_TURNS != 0);
  localparam bit         HAS_GAP     = (GAP_CYCLES != 0);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       any_win;

  assign any_win = win1 | win2;

  // Next-state and wait-counter logic; turn_count already holds the new value while in SAMPLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (any_win) begin
          state_nxt = S_OVER;
        end else if (start | step) begin
          state_nxt = S_ROLL;
        end
      end
      S_ROLL: begin
        state_nxt = S_SETTLE;
        cnt_nxt   = SETTLE_LOAD;
      end
      S_SETTLE: begin
        if (cnt == 8'd0) begin
          state_nxt = S_SAMPLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_SAMPLE: begin
        if (any_win) begin
          state_nxt = S_OVER;
        end else if (LIMIT_ON && (turn_count == TURN_LIMIT)) begin
          state_nxt = S_OVER;
        end else begin
          state_nxt = S_SWITCH;
        end
      end
      S_SWITCH: begin
        if (HAS_GAP) begin
          state_nxt = S_GAP;
          cnt_nxt   = GAP_LOAD;
        end else begin
          state_nxt = start ? S_ROLL : S_IDLE;
        end
      end
      S_GAP: begin
        if (cnt == 8'd0) begin
          state_nxt = start ? S_ROLL : S_IDLE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_OVER: begin
        state_nxt = S_OVER;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 8'd0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= 8'd0;
      roll          <= 1'b0;
      player_switch <= 1'b1;
      busy          <= 1'b0;
      turn_done     <= 1'b0;
      last_pos1     <= '0;
      last_pos2     <= '0;
      turn_count    <= 8'd0;
      winner        <= 2'b00;
      game_over     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      roll      <= (state_nxt == S_ROLL);
      busy      <= (state_nxt != S_IDLE) && (state_nxt != S_OVER);
      turn_done <= (state_nxt == S_SAMPLE);
      game_over <= (state_nxt == S_OVER);
      // Positions and count are taken on entry to SAMPLE so they are valid alongside turn_done.
      if (state_nxt == S_SAMPLE) begin
        last_pos1 <= position1;
        last_pos2 <= position2;
        if (turn_count != 8'hFF) begin
          turn_count <= turn_count + 8'd1;
        end
      end
      if (state_nxt == S_SWITCH) begin
        player_switch <= ~player_switch;
      end
      // Win flags are zero on the turn-limit path, so this also yields 00 there.
      if ((state_nxt == S_OVER) && (state != S_OVER)) begin
        winner <= {win2, win1};
      end
    end
  end

endmodule

// File: tb/tb_dice_turn_sequencer.sv
// Directed bench for dice_turn_sequencer: default instance plus a MAX_TURNS=4 instance on shared inputs.
module tb_dice_turn_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step = 1'b0;
  logic [6:0] position1 = 7'd0;
  logic [6:0] position2 = 7'd0;
  logic       win1 = 1'b0;
  logic       win2 = 1'b0;

  logic       roll, player_switch, busy, turn_done, game_over;
  logic [6:0] last_pos1, last_pos2;
  logic [7:0] turn_count;
  logic [1:0] winner;

  logic       roll_m, player_switch_m, busy_m, turn_done_m, game_over_m;
  logic [6:0] last_pos1_m, last_pos2_m;
  logic [7:0] turn_count_m;
  logic [1:0] winner_m;

  dice_turn_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .position1(position1), .position2(position2), .win1(win1), .win2(win2),
    .roll(roll), .player_switch(player_switch), .busy(busy), .turn_done(turn_done),
    .last_pos1(last_pos1), .last_pos2(last_pos2), .turn_count(turn_count),
    .winner(winner), .game_over(game_over)
  );

  dice_turn_sequencer #(.MAX_TURNS(4)) dut_m (
    .clk(clk), .reset(reset), .start(start), .step(step),
    .position1(position1), .position2(position2), .win1(win1), .win2(win2),
    .roll(roll_m), .player_switch(player_switch_m), .busy(busy_m), .turn_done(turn_done_m),
    .last_pos1(last_pos1_m), .last_pos2(last_pos2_m), .turn_count(turn_count_m),
    .winner(winner_m), .game_over(game_over_m)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [6:0] p1;
    logic [6:0] p2;
    int         exp_cnt;
    int         exp_ps;
  } vec_t;

  vec_t vecs[4];

  int n, nrolls, last_roll, first_roll, bad_gap, bad_ps, ntd, td4, go, r3;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Successive single-step turns: player_switch starts at 1 and toggles each completed turn.
    vecs[0] = '{p1: 7'd5,   p2: 7'd0,  exp_cnt: 1, exp_ps: 0};
    vecs[1] = '{p1: 7'd12,  p2: 7'd33, exp_cnt: 2, exp_ps: 1};
    vecs[2] = '{p1: 7'd127, p2: 7'd64, exp_cnt: 3, exp_ps: 0};
    vecs[3] = '{p1: 7'd0,   p2: 7'd99, exp_cnt: 4, exp_ps: 1};

    // Reset state after two cycles of reset.
    tick();
    tick();
    check("rst_roll", roll, 0);
    check("rst_ps", player_switch, 1);
    check("rst_count", turn_count, 0);
    check("rst_busy", busy, 0);
    check("rst_winner", winner, 0);
    check("rst_over", game_over, 0);
    check("rst_turn_done", turn_done, 0);
    reset = 1'b0;
    tick();

    // Table: one step-driven turn per record.
    for (int i = 0; i < 4; i++) begin
      position1 = vecs[i].p1;
      position2 = vecs[i].p2;
      step = 1'b1;
      tick();
      check("step_roll_on", roll, 1);
      step = 1'b0;
      tick();
      check("step_roll_off", roll, 0);
      n = 1;
      while (!turn_done && n < 30) begin
        tick();
        n++;
      end
      // SAMPLE is the sixth cycle of the turn, five edges after the roll cycle.
      check("turn_done_lat", n, 5);
      tick();
      check("turn_done_pulse", turn_done, 0);
      check("last_pos1", last_pos1, vecs[i].p1);
      check("last_pos2", last_pos2, vecs[i].p2);
      check("turn_count", turn_count, vecs[i].exp_cnt);
      check("ps_after", player_switch, vecs[i].exp_ps);
      tick();
      tick();
      check("busy_in_gap", busy, 1);
      tick();
      check("back_idle", busy, 0);
    end

    // Step while busy is dropped.
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    nrolls = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (roll) nrolls++;
    end
    check("busy_step_rolls", nrolls, 0);
    check("busy_step_count", turn_count, 5);
    check("busy_step_idle", busy, 0);

    // Auto-play for 90 cycles, starting with start and step together.
    do_reset();
    start = 1'b1;
    step = 1'b1;
    nrolls = 0;
    last_roll = -1;
    first_roll = -1;
    bad_gap = 0;
    bad_ps = 0;
    for (int c = 0; c < 90; c++) begin
      tick();
      step = 1'b0;
      if (roll) begin
        if (nrolls == 0) first_roll = c;
        else if (c - last_roll != 9) bad_gap++;
        if (int'(player_switch) != ((nrolls % 2 == 0) ? 1 : 0)) bad_ps++;
        last_roll = c;
        nrolls++;
      end
    end
    start = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    check("auto_first_roll", first_roll, 0);
    check("auto_nrolls", nrolls, 10);
    check("auto_period_errs", bad_gap, 0);
    check("auto_ps_errs", bad_ps, 0);
    check("auto_count", turn_count, 10);
    check("auto_ps_end", player_switch, 1);
    check("auto_idle", busy, 0);

    // Win1 raised during SETTLE of turn 3.
    do_reset();
    start = 1'b1;
    nrolls = 0;
    n = 0;
    while (nrolls < 3 && n < 40) begin
      tick();
      n++;
      if (roll) nrolls++;
    end
    check("win_third_roll", nrolls, 3);
    tick();
    win1 = 1'b1;
    r3 = 1;
    while (!game_over && r3 < 20) begin
      tick();
      r3++;
      if (roll) nrolls++;
    end
    check("win_over_lat", r3, 6);
    check("win_winner", winner, 1);
    check("win_count", turn_count, 3);
    check("win_busy", busy, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (roll) nrolls++;
    end
    check("win_no_more_rolls", nrolls, 3);
    check("win_over_held", game_over, 1);
    start = 1'b0;
    win1 = 1'b0;

    // Turn limit of 4 on the second instance.
    do_reset();
    start = 1'b1;
    ntd = 0;
    td4 = -1;
    go = -1;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (turn_done_m) begin
        ntd++;
        if (ntd == 4) td4 = c;
      end
      if (game_over_m) begin
        go = c;
        break;
      end
    end
    check("lim_turn_dones", ntd, 4);
    check("lim_over_after_td", go - td4, 1);
    check("lim_winner", winner_m, 0);
    check("lim_count", turn_count_m, 4);
    check("lim_ps_held", player_switch_m, 0);
    nrolls = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (roll_m) nrolls++;
    end
    check("lim_no_rolls", nrolls, 0);
    start = 1'b0;

    // Reset in SETTLE after one completed turn.
    do_reset();
    position1 = 7'd9;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    n = 0;
    while (busy && n < 30) begin
      tick();
      n++;
    end
    check("pre_ps", player_switch, 0);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    check("pre_busy", busy, 1);
    reset = 1'b1;
    tick();
    check("midrst_busy", busy, 0);
    check("midrst_roll", roll, 0);
    check("midrst_ps", player_switch, 1);
    check("midrst_count", turn_count, 0);
    check("midrst_pos1", last_pos1, 0);
    reset = 1'b0;
    nrolls = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (roll) nrolls++;
    end
    check("midrst_no_roll", nrolls, 0);

    // Both wins at SAMPLE gives a tie.
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    win1 = 1'b1;
    win2 = 1'b1;
    n = 0;
    while (!game_over && n < 20) begin
      tick();
      n++;
    end
    check("tie_over", game_over, 1);
    check("tie_winner", winner, 3);
    check("tie_count", turn_count, 1);
    win1 = 1'b0;

    // Win seen while IDLE ends the game without a turn.
    do_reset();
    tick();
    tick();
    check("idle_win_over", game_over, 1);
    check("idle_win_winner", winner, 2);
    check("idle_win_count", turn_count, 0);
    win2 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
